// File: rtl/fdiv_ctrl_pkg.sv
// Shared types and helpers for the fdiv speed-level controller.
package fdiv_ctrl_pkg;

    localparam int unsigned DIV_W = 10;

    typedef enum logic [1:0] {RUN, APPLY, PAUSED} fdiv_ctrl_state_t;

    // Divider value for a level: halves per level, never below 1.
    function automatic logic [DIV_W-1:0] level_to_div(input logic [31:0] level,
                                                      input logic [DIV_W-1:0] div_max);
        logic [DIV_W-1:0] d;
        d = div_max >> level;
        if (d == '0) begin
            d = {{(DIV_W-1){1'b0}}, 1'b1};
        end
        return d;
    endfunction

endpackage

// File: rtl/tick_edge_det.sv
// Registered rising-edge detector with synchronous clear of the history bit.
module tick_edge_det (
    input  logic clkin,
    input  logic reset,
    input  logic clr,
    input  logic d,
    output logic pulse
);

    logic prev_q;
    logic pulse_q;

    always_ff @(posedge clkin) begin
        if (reset) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= clr ? 1'b0 : d;
            pulse_q <= d & ~prev_q & ~clr;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/fdiv_speed_ctrl.sv
// Speed-level controller: drives fdiv's div/reset and turns its clkout into
// single-cycle tick pulses.
module fdiv_speed_ctrl
    import fdiv_ctrl_pkg::*;
#(
    parameter int unsigned       NUM_LEVELS   = 8,
    parameter logic [DIV_W-1:0]  DIV_MAX      = 10'd512,
    parameter int unsigned       APPLY_CYCLES = 2,
    parameter int unsigned       TCNT_W       = 16,
    localparam int unsigned      LW           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              speed_up,
    input  logic              speed_down,
    input  logic              pause,
    input  logic              tick_in,
    output logic [DIV_W-1:0]  div_out,
    output logic              div_reset,
    output logic              tick,
    output logic [LW-1:0]     level,
    output logic              busy,
    output logic [TCNT_W-1:0] tick_cnt
);

    localparam int unsigned ACW = $clog2(APPLY_CYCLES + 1);

    fdiv_ctrl_state_t  state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [ACW-1:0]    apply_cnt_q, apply_cnt_d;
    logic [TCNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              tick_pulse;
    logic              edge_clr;

    always_comb begin
        state_d     = state_q;
        level_d     = level_q;
        apply_cnt_d = apply_cnt_q;
        case (state_q)
            RUN: begin
                if (pause) begin
                    state_d = PAUSED;
                end else if (speed_up && !speed_down && level_q != LW'(NUM_LEVELS - 1)) begin
                    level_d     = level_q + LW'(1);
                    state_d     = APPLY;
                    apply_cnt_d = '0;
                end else if (speed_down && !speed_up && level_q != '0) begin
                    level_d     = level_q - LW'(1);
                    state_d     = APPLY;
                    apply_cnt_d = '0;
                end
            end
            APPLY: begin
                if (apply_cnt_q == ACW'(APPLY_CYCLES - 1)) begin
                    state_d     = pause ? PAUSED : RUN;
                    apply_cnt_d = '0;
                end else begin
                    apply_cnt_d = apply_cnt_q + ACW'(1);
                end
            end
            PAUSED: begin
                if (!pause) begin
                    state_d     = APPLY;
                    apply_cnt_d = '0;
                end
            end
            default: begin
                state_d     = APPLY;
                apply_cnt_d = '0;
            end
        endcase
    end

    assign div_d = level_to_div(32'(level_d), DIV_MAX);

    // Clearing on the exit edge too suppresses a tick_in edge coinciding with
    // the move into APPLY or PAUSED.
    assign edge_clr = (state_q != RUN) || (state_d != RUN);

    tick_edge_det u_edge (
        .clkin (clkin),
        .reset (reset),
        .clr   (edge_clr),
        .d     (tick_in),
        .pulse (tick_pulse)
    );

    // The visible count includes the tick being emitted this cycle.
    assign tick_cnt_d = tick_cnt_q + TCNT_W'(tick_pulse);

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= APPLY;
            level_q     <= '0;
            div_q       <= DIV_MAX;
            apply_cnt_q <= '0;
            tick_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            div_q       <= div_d;
            apply_cnt_q <= apply_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
        end
    end

    assign div_out   = div_q;
    assign div_reset = (state_q != RUN);
    assign busy      = (state_q != RUN);
    assign tick      = tick_pulse;
    assign level     = level_q;
    assign tick_cnt  = tick_cnt_d;

endmodule

// File: tb/tb_fdiv_speed_ctrl.sv
// Directed bench for fdiv_speed_ctrl; a 4-bit-counter twin checks the tick_cnt wrap.
module tb_fdiv_speed_ctrl;

    logic        clkin = 1'b0;
    logic        reset;
    logic        speed_up;
    logic        speed_down;
    logic        pause;
    logic        tick_in;
    logic [9:0]  div_out;
    logic        div_reset;
    logic        tick;
    logic [2:0]  level;
    logic        busy;
    logic [15:0] tick_cnt;

    logic [9:0]  div_out_s;
    logic        div_reset_s;
    logic        tick_s;
    logic [2:0]  level_s;
    logic        busy_s;
    logic [3:0]  tick_cnt_s;

    int ntests = 0;
    int nfail  = 0;

    always #5 clkin = ~clkin;

    fdiv_speed_ctrl dut (
        .clkin      (clkin),
        .reset      (reset),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .pause      (pause),
        .tick_in    (tick_in),
        .div_out    (div_out),
        .div_reset  (div_reset),
        .tick       (tick),
        .level      (level),
        .busy       (busy),
        .tick_cnt   (tick_cnt)
    );

    fdiv_speed_ctrl #(.TCNT_W(4)) dut_w4 (
        .clkin      (clkin),
        .reset      (reset),
        .speed_up   (speed_up),
        .speed_down (speed_down),
        .pause      (pause),
        .tick_in    (tick_in),
        .div_out    (div_out_s),
        .div_reset  (div_reset_s),
        .tick       (tick_s),
        .level      (level_s),
        .busy       (busy_s),
        .tick_cnt   (tick_cnt_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clkin);
        #1;
    endtask

    // One request cycle, then check level/div and, if a change is expected,
    // the 2-cycle APPLY window.
    task automatic req(input logic u, input logic d, input int exp_lvl, input bit exp_apply);
        logic [9:0] exp_div;
        exp_div    = 10'd512 >> exp_lvl;
        speed_up   = u;
        speed_down = d;
        cyc();
        speed_up   = 1'b0;
        speed_down = 1'b0;
        chk("req_level", 32'(level), 32'(exp_lvl));
        chk("req_div", 32'(div_out), 32'(exp_div));
        chk("req_busy", 32'(busy), 32'(exp_apply));
        chk("req_divrst", 32'(div_reset), 32'(exp_apply));
        if (exp_apply) begin
            cyc();
            chk("apply_busy2", 32'(busy), 32'd1);
            cyc();
            chk("apply_done", 32'(busy), 32'd0);
            chk("apply_done_rst", 32'(div_reset), 32'd0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        speed_up   = 1'b0;
        speed_down = 1'b0;
        pause      = 1'b0;
        tick_in    = 1'b0;

        // 1. reset and release
        repeat (3) cyc();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_div", 32'(div_out), 32'd512);
        chk("rst_divrst", 32'(div_reset), 32'd1);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_cnt", 32'(tick_cnt), 32'd0);
        reset = 1'b0;
        cyc();
        chk("rel_c1_divrst", 32'(div_reset), 32'd1);
        chk("rel_c1_busy", 32'(busy), 32'd1);
        cyc();
        chk("rel_c2_divrst", 32'(div_reset), 32'd0);
        chk("rel_c2_busy", 32'(busy), 32'd0);
        chk("rel_div", 32'(div_out), 32'd512);
        chk("rel_level", 32'(level), 32'd0);

        // 3a. speed_down at level 0 is ignored
        req(1'b0, 1'b1, 0, 1'b0);

        // 2. three spaced speed_up pulses
        for (int i = 1; i <= 3; i++) begin
            req(1'b1, 1'b0, i, 1'b1);
            cyc();
            cyc();
        end
        chk("lvl3_div", 32'(div_out), 32'd64);

        // 3b. climb to the top, saturate, then walk back down
        for (int i = 4; i <= 7; i++) req(1'b1, 1'b0, i, 1'b1);
        req(1'b1, 1'b0, 7, 1'b0);
        for (int i = 6; i >= 0; i--) req(1'b0, 1'b1, i, 1'b1);
        req(1'b0, 1'b1, 0, 1'b0);

        // 4. simultaneous up/down at level 1
        req(1'b1, 1'b0, 1, 1'b1);
        req(1'b1, 1'b1, 1, 1'b0);

        // 5. tick generation
        tick_in = 1'b0;
        cyc();
        chk("tk_pre", 32'(tick), 32'd0);
        chk("tk_pre_cnt", 32'(tick_cnt), 32'd0);
        tick_in = 1'b1;
        cyc();
        chk("tk_hi", 32'(tick), 32'd1);
        chk("tk_hi_cnt", 32'(tick_cnt), 32'd1);
        cyc();
        chk("tk_one_cycle", 32'(tick), 32'd0);
        chk("tk_cnt_hold", 32'(tick_cnt), 32'd1);
        tick_in = 1'b0;
        cyc();

        // pause beats speed_up; coincident tick_in edge is swallowed
        tick_in  = 1'b1;
        pause    = 1'b1;
        speed_up = 1'b1;
        cyc();
        speed_up = 1'b0;
        chk("pz_tick", 32'(tick), 32'd0);
        chk("pz_busy", 32'(busy), 32'd1);
        chk("pz_divrst", 32'(div_reset), 32'd1);
        chk("pz_level", 32'(level), 32'd1);
        chk("pz_cnt", 32'(tick_cnt), 32'd1);
        for (int k = 0; k < 19; k++) begin
            tick_in  = ~tick_in;
            speed_up = (k == 5);
            cyc();
            chk("pz_hold_tick", 32'(tick), 32'd0);
            chk("pz_hold_divrst", 32'(div_reset), 32'd1);
        end
        speed_up = 1'b0;
        pause    = 1'b0;
        tick_in  = 1'b0;
        cyc();
        chk("unpz_apply1", 32'(busy), 32'd1);
        cyc();
        chk("unpz_apply2", 32'(div_reset), 32'd1);
        cyc();
        chk("unpz_run_busy", 32'(busy), 32'd0);
        chk("unpz_run_rst", 32'(div_reset), 32'd0);
        chk("unpz_level", 32'(level), 32'd1);
        chk("unpz_cnt", 32'(tick_cnt), 32'd1);

        // 6. wrap: 15 more ticks take the 4-bit twin from 1 through 15 to 0
        for (int n = 0; n < 15; n++) begin
            tick_in = 1'b1;
            cyc();
            chk("wr_tick", 32'(tick), 32'd1);
            chk("wr_cnt", 32'(tick_cnt), 32'(n + 2));
            chk("wr_cnt4", 32'(tick_cnt_s), 32'((n + 2) % 16));
            tick_in = 1'b0;
            cyc();
        end
        chk("wr_final16", 32'(tick_cnt), 32'd16);
        chk("wr_final4", 32'(tick_cnt_s), 32'd0);
        chk("w4_level", 32'(level_s), 32'd1);
        chk("w4_div", 32'(div_out_s), 32'd256);
        chk("w4_busy", 32'(busy_s), 32'd0);
        chk("w4_divrst", 32'(div_reset_s), 32'd0);
        chk("w4_tick", 32'(tick_s), 32'd0);

        // reset in the middle of APPLY
        speed_up = 1'b1;
        cyc();
        speed_up = 1'b0;
        chk("ra_busy", 32'(busy), 32'd1);
        chk("ra_level", 32'(level), 32'd2);
        reset = 1'b1;
        cyc();
        chk("ra_rst_level", 32'(level), 32'd0);
        chk("ra_rst_div", 32'(div_out), 32'd512);
        chk("ra_rst_divrst", 32'(div_reset), 32'd1);
        chk("ra_rst_busy", 32'(busy), 32'd1);
        chk("ra_rst_tick", 32'(tick), 32'd0);
        chk("ra_rst_cnt", 32'(tick_cnt), 32'd0);
        reset = 1'b0;
        cyc();
        cyc();
        chk("ra_run_busy", 32'(busy), 32'd0);
        chk("ra_run_level", 32'(level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
